// File: rtl/alu_cmd_sequencer.sv
// Single-outstanding command sequencer in front of a 1-cycle registered ALU.
// Rejects NOP and divide-by-zero without touching the ALU; otherwise issues, waits, and returns the selected result.
module alu_cmd_sequencer #(
  parameter int unsigned A_WIDTH     = 16,
  parameter int unsigned B_WIDTH     = 16,
  parameter int unsigned ARITH_WIDTH = 32,
  parameter int unsigned LOGIC_WIDTH = 16,
  parameter int unsigned CMP_WIDTH   = 16,
  parameter int unsigned SHIFT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [A_WIDTH-1:0]     CMD_A,
  input  logic [B_WIDTH-1:0]     CMD_B,
  input  logic [3:0]             CMD_FUNC,
  output logic [A_WIDTH-1:0]     ALU_A,
  output logic [B_WIDTH-1:0]     ALU_B,
  output logic [3:0]             ALU_FUNC,
  input  logic [ARITH_WIDTH-1:0] ALU_ARITH_OUT,
  input  logic                   ALU_CARRY_OUT,
  input  logic [LOGIC_WIDTH-1:0] ALU_LOGIC_OUT,
  input  logic [CMP_WIDTH-1:0]   ALU_CMP_OUT,
  input  logic [SHIFT_WIDTH-1:0] ALU_SHIFT_OUT,
  input  logic                   ALU_ARITH_FLAG,
  input  logic                   ALU_LOGIC_FLAG,
  input  logic                   ALU_CMP_FLAG,
  input  logic                   ALU_SHIFT_FLAG,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic [ARITH_WIDTH-1:0] RSP_DATA,
  output logic                   RSP_CARRY,
  output logic                   RSP_ERR,
  output logic [15:0]            TXN_COUNT
);

  localparam logic [3:0] FUNC_NOP = 4'b1000;
  localparam logic [3:0] FUNC_DIV = 4'b0011;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             cls_q, cls_d;
  logic [A_WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [B_WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [3:0]             alu_func_q, alu_func_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [ARITH_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_carry_q, rsp_carry_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [15:0]            txn_count_q, txn_count_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = FUNC_NOP;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    txn_count_d = txn_count_q;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          cls_d = CMD_FUNC[3:2];
          if (CMD_FUNC == FUNC_NOP || (CMD_FUNC == FUNC_DIV && CMD_B == '0)) begin
            state_d     = ST_RESP;
            rsp_data_d  = '0;
            rsp_carry_d = 1'b0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            alu_a_d    = CMD_A;
            alu_b_d    = CMD_B;
            alu_func_d = CMD_FUNC;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // ALU result is valid now; capture the class chosen at acceptance
        state_d     = ST_RESP;
        rsp_carry_d = 1'b0;
        case (cls_q)
          2'b00: begin
            rsp_data_d  = ALU_ARITH_OUT;
            rsp_carry_d = ALU_CARRY_OUT;
            rsp_err_d   = ~ALU_ARITH_FLAG;
          end
          2'b01: begin
            rsp_data_d = ARITH_WIDTH'(ALU_LOGIC_OUT);
            rsp_err_d  = ~ALU_LOGIC_FLAG;
          end
          2'b10: begin
            rsp_data_d = ARITH_WIDTH'(ALU_CMP_OUT);
            rsp_err_d  = ~ALU_CMP_FLAG;
          end
          default: begin
            rsp_data_d = ARITH_WIDTH'(ALU_SHIFT_OUT);
            rsp_err_d  = ~ALU_SHIFT_FLAG;
          end
        endcase
      end
      ST_RESP: begin
        if (RSP_READY) begin
          state_d     = ST_IDLE;
          txn_count_d = txn_count_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      cls_q       <= 2'b00;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= FUNC_NOP;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      txn_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUNC  = alu_func_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_CARRY = rsp_carry_q;
  assign RSP_ERR   = rsp_err_q;
  assign TXN_COUNT = txn_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a 1-cycle registered ALU model.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a, cmd_b;
  logic [3:0]  cmd_func;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_func;
  logic [31:0] alu_arith;
  logic        alu_carry;
  logic [15:0] alu_logic, alu_cmp, alu_shift;
  logic        arith_flag = 1'b1, logic_flag = 1'b1, cmp_flag = 1'b1, shift_flag = 1'b1;
  logic        rsp_valid, rsp_ready, rsp_carry, rsp_err;
  logic [31:0] rsp_data;
  logic [15:0] txn_count;
  logic [15:0] cmp_val;
  logic        mon_en;
  logic        func_bad = 1'b0;
  int          n_pass = 0, n_chk = 0, lat;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_FUNC(cmd_func),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUNC(alu_func),
    .ALU_ARITH_OUT(alu_arith), .ALU_CARRY_OUT(alu_carry),
    .ALU_LOGIC_OUT(alu_logic), .ALU_CMP_OUT(alu_cmp), .ALU_SHIFT_OUT(alu_shift),
    .ALU_ARITH_FLAG(arith_flag), .ALU_LOGIC_FLAG(logic_flag),
    .ALU_CMP_FLAG(cmp_flag), .ALU_SHIFT_FLAG(shift_flag),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_DATA(rsp_data), .RSP_CARRY(rsp_carry), .RSP_ERR(rsp_err),
    .TXN_COUNT(txn_count)
  );

  // ALU model: all results registered one cycle after the inputs
  always @(posedge clk) begin
    logic [31:0] sum;
    sum = 32'(alu_a) + 32'(alu_b);
    alu_arith <= sum;
    alu_carry <= sum[16];
    alu_logic <= alu_a & alu_b;
    alu_cmp   <= cmp_val;
    alu_shift <= alu_a << alu_b[3:0];
  end

  always @(negedge clk)
    if (mon_en && alu_func !== 4'b1000) func_bad = 1'b1;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge
  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_func = f;
    chk("cmd_ready_at_offer", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // lat = index of the first edge after acceptance at which RSP_VALID is seen high
  task automatic wait_rsp(output int l);
    l = 1;
    while (rsp_valid !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_func = '0;
    rsp_ready = 1'b1; mon_en = 1'b0; cmp_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_func", 32'(alu_func), 32'h8);
    chk("rst_txn", 32'(txn_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 6 + 3
    accept(16'd6, 16'd3, 4'b0000);
    chk("issue_alu_func", 32'(alu_func), 32'h0);
    chk("issue_alu_a", 32'(alu_a), 32'd6);
    chk("issue_alu_b", 32'(alu_b), 32'd3);
    chk("issue_cmd_ready", 32'(cmd_ready), 32'd0);
    wait_rsp(lat);
    chk("add_lat", 32'(lat), 32'd3);
    chk("add_data", rsp_data, 32'd9);
    chk("add_carry", 32'(rsp_carry), 32'd0);
    chk("add_err", 32'(rsp_err), 32'd0);
    chk("add_alu_func_idle", 32'(alu_func), 32'h8);
    @(negedge clk);
    chk("add_txn", 32'(txn_count), 32'd1);
    chk("add_valid_drop", 32'(rsp_valid), 32'd0);

    // 0xFFFF + 0xFFFF carries out
    accept(16'hFFFF, 16'hFFFF, 4'b0000);
    wait_rsp(lat);
    chk("addc_lat", 32'(lat), 32'd3);
    chk("addc_data", rsp_data, 32'h0001FFFE);
    chk("addc_carry", 32'(rsp_carry), 32'd1);
    chk("addc_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    chk("addc_txn", 32'(txn_count), 32'd2);

    // Rejected commands never reach the ALU
    mon_en = 1'b1;
    accept(16'd6, 16'd0, 4'b0011);
    wait_rsp(lat);
    chk("div0_lat", 32'(lat), 32'd1);
    chk("div0_data", rsp_data, 32'd0);
    chk("div0_carry", 32'(rsp_carry), 32'd0);
    chk("div0_err", 32'(rsp_err), 32'd1);
    @(negedge clk);
    chk("div0_txn", 32'(txn_count), 32'd3);
    accept(16'd6, 16'd3, 4'b1000);
    wait_rsp(lat);
    chk("nop_lat", 32'(lat), 32'd1);
    chk("nop_data", rsp_data, 32'd0);
    chk("nop_err", 32'(rsp_err), 32'd1);
    @(negedge clk);
    mon_en = 1'b0;
    chk("nop_txn", 32'(txn_count), 32'd4);
    chk("reject_alu_func_quiet", 32'(func_bad), 32'd0);
    chk("reject_alu_a_held", 32'(alu_a), 32'hFFFF);

    // Compare class, then with its flag missing
    cmp_val = 16'd2;
    accept(16'd6, 16'd3, 4'b1010);
    wait_rsp(lat);
    chk("cmp_lat", 32'(lat), 32'd3);
    chk("cmp_data", rsp_data, 32'h2);
    chk("cmp_carry", 32'(rsp_carry), 32'd0);
    chk("cmp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    cmp_flag = 1'b0;
    accept(16'd6, 16'd3, 4'b1010);
    wait_rsp(lat);
    chk("cmpnf_data", rsp_data, 32'h2);
    chk("cmpnf_err", 32'(rsp_err), 32'd1);
    @(negedge clk);
    cmp_flag = 1'b1;
    chk("cmpnf_txn", 32'(txn_count), 32'd6);

    // Logic class masks the arith carry; shift class
    accept(16'hFFFF, 16'hFFFF, 4'b0100);
    wait_rsp(lat);
    chk("logic_data", rsp_data, 32'h0000FFFF);
    chk("logic_carry", 32'(rsp_carry), 32'd0);
    @(negedge clk);
    accept(16'd6, 16'd3, 4'b1100);
    wait_rsp(lat);
    chk("shift_data", rsp_data, 32'h30);
    chk("shift_err", 32'(rsp_err), 32'd0);
    @(negedge clk);

    // Backpressure with a second command waiting
    rsp_ready = 1'b0;
    accept(16'd6, 16'd3, 4'b0000);
    wait_rsp(lat);
    chk("bp_lat", 32'(lat), 32'd3);
    cmd_valid = 1'b1; cmd_a = 16'd1; cmd_b = 16'd2; cmd_func = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_data_held", rsp_data, 32'd9);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_txn", 32'(txn_count), 32'd9);
    chk("bp_ready_after_hs", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("bp2_lat", 32'(lat), 32'd3);
    chk("bp2_data", rsp_data, 32'd3);
    @(negedge clk);
    chk("bp2_txn", 32'(txn_count), 32'd10);

    // Reset while in WAIT drops the command
    accept(16'd7, 16'd7, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rstw_valid", 32'(rsp_valid), 32'd0);
    chk("rstw_txn", 32'(txn_count), 32'd0);
    chk("rstw_alu_func", 32'(alu_func), 32'h8);
    repeat (4) @(negedge clk);
    chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
    accept(16'd6, 16'd3, 4'b0000);
    wait_rsp(lat);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", rsp_data, 32'd9);
    @(negedge clk);
    chk("post_rst_txn", 32'(txn_count), 32'd1);

    // Jump the counter to 0xFFFF instead of spending ~131k cycles counting up
    force dut.txn_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.txn_count_q;
    @(negedge clk);
    chk("preload_txn", 32'(txn_count), 32'hFFFF);
    accept(16'd0, 16'd0, 4'b1000);
    wait_rsp(lat);
    @(negedge clk);
    chk("wrap_txn", 32'(txn_count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
